// File: rtl/rf_wb_pkg.sv
// Shared constants and state encoding for the register-file write-back arbiter.
package rf_wb_pkg;

  localparam int unsigned XLEN_D   = 32;
  localparam int unsigned AW_D     = 5;
  localparam int unsigned NREG     = 32;
  localparam int unsigned LAST_REG = 31;

  typedef enum logic {
    ARB,
    CLEAR
  } state_t;

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Combinational round-robin grant generator: first asserted request at or after rr_ptr wins.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    if (enable) begin
      for (int unsigned off = 0; off < NREQ; off++) begin
        idx = PW'((32'(rr_ptr) + off) % NREQ);
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = idx;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and soft-clear sequencer for the integer register file write port.
// Optional in-flight forwarding enabled by RF_WB_ARBITER_FORWARD_EN.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned XLEN = XLEN_D,
  parameter int unsigned AW   = AW_D
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 clr_done,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_addr,
  output logic [XLEN-1:0]      rf_data,
  input  logic [AW-1:0]        fwd_addr,
  output logic                 fwd_hit,
  output logic [XLEN-1:0]      fwd_data
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_addr_q, rf_addr_d;
  logic [XLEN-1:0] rf_data_q, rf_data_d;
  logic            clr_done_q, clr_done_d;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            arb_en;
  logic            accept;
  logic [AW-1:0]   addr_g;
  logic [XLEN-1:0] data_g;

  // Gating with rst keeps req_ready low for the whole reset assertion.
  assign arb_en = rst && (state_q == ARB) && !clr_req;

  rr_arbiter #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_rr (
    .req      (req_valid),
    .rr_ptr   (rr_ptr_q),
    .enable   (arb_en),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign addr_g    = req_addr[grant_idx*AW +: AW];
  assign data_g    = req_data[grant_idx*XLEN +: XLEN];

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    clr_cnt_d  = clr_cnt_q;
    rf_we_d    = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    clr_done_d = 1'b0;
    unique case (state_q)
      ARB: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = AW'(1);
        end else if (accept) begin
          rf_addr_d = addr_g;
          rf_data_d = data_g;
          rf_we_d   = (addr_g != '0);
          rr_ptr_d  = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      CLEAR: begin
        rf_we_d   = 1'b1;
        rf_addr_d = clr_cnt_q;
        rf_data_d = '0;
        if (clr_cnt_q == AW'(LAST_REG)) begin
          state_d    = ARB;
          clr_cnt_d  = '0;
          clr_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      clr_cnt_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      clr_cnt_q  <= clr_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign clr_done = clr_done_q;
  assign rf_we    = rf_we_q;
  assign rf_addr  = rf_addr_q;
  assign rf_data  = rf_data_q;

`ifdef RF_WB_ARBITER_FORWARD_EN
  assign fwd_hit  = rf_we_q && (rf_addr_q == fwd_addr) && (fwd_addr != '0);
  assign fwd_data = rf_data_q;
`else
  logic unused_fwd;
  assign unused_fwd = ^fwd_addr;
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule
